// File: rtl/id_pipe_stage.sv
// ID stage: decodes MIPS fields and holds them in a 2-entry skid buffer at the
// ID/EX boundary, with flush, load-use bubble insertion and a saturating stall counter.
module id_pipe_stage #(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_W-1:0]     in_pc_plus4,
    input  logic [INST_W-1:0]     in_inst,
    input  logic                  flush,
    input  logic                  ex_load_valid,
    input  logic [REG_ADDR_W-1:0] ex_load_rt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_pc_plus4,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [5:0]            out_opcode,
    output logic [5:0]            out_funct,
    output logic [DATA_W-1:0]     out_imm_signed,
    output logic [DATA_W-1:0]     out_imm_unsigned,
    output logic [DATA_W-1:0]     out_shamt,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]     pc_plus4;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [5:0]            opcode;
        logic [5:0]            funct;
        logic [DATA_W-1:0]     imm_signed;
        logic [DATA_W-1:0]     imm_unsigned;
        logic [DATA_W-1:0]     shamt;
    } entry_t;

    state_t state, state_nxt;
    entry_t decoded, head, skid;
    logic   hazard, accept, issue;
    logic   load_head_new, load_skid_new, head_from_skid;

    always_comb begin
        decoded              = '0;
        decoded.pc_plus4     = in_pc_plus4;
        decoded.rs           = REG_ADDR_W'(in_inst[25:21]);
        decoded.rt           = REG_ADDR_W'(in_inst[20:16]);
        decoded.rd           = REG_ADDR_W'(in_inst[15:11]);
        decoded.opcode       = in_inst[31:26];
        decoded.funct        = in_inst[5:0];
        decoded.imm_signed   = DATA_W'($signed(in_inst[15:0]));
        decoded.imm_unsigned = DATA_W'(in_inst[15:0]);
        decoded.shamt        = DATA_W'(in_inst[10:6]);
    end

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high. in_ready depends only on registered occupancy; out_valid is dropped
    // while a load-use hazard holds the head. flush cancels both transfers.
    always_comb begin
        hazard    = ex_load_valid && (state != EMPTY) && (ex_load_rt != '0) &&
                    ((ex_load_rt == head.rs) || (ex_load_rt == head.rt));
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY) && !hazard;
        accept    = in_valid && in_ready && !flush;
        issue     = out_valid && out_ready && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_head_new  = 1'b0;
        load_skid_new  = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt     = ONE;
                        load_head_new = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        load_head_new = 1'b1;
                    end else if (accept) begin
                        state_nxt     = TWO;
                        load_skid_new = 1'b1;
                    end else if (issue) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (issue) begin
                        state_nxt      = ONE;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_new)       head <= decoded;
            else if (head_from_skid) head <= skid;
            if (load_skid_new)       skid <= decoded;
        end
    end

    // Counts every hazard cycle, sticking at all-ones; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst)                         stall_cnt <= '0;
        else if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end

    always_comb begin
        out_pc_plus4     = head.pc_plus4;
        out_rs           = head.rs;
        out_rt           = head.rt;
        out_rd           = head.rd;
        out_opcode       = head.opcode;
        out_funct        = head.funct;
        out_imm_signed   = head.imm_signed;
        out_imm_unsigned = head.imm_unsigned;
        out_shamt        = head.shamt;
        dbg_state        = state;
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Testbench for id_pipe_stage: directed MIPS vectors with hand-decoded fields,
// expected-queue scoreboard and a negedge monitor that pops on every issue.
module tb_id_pipe_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        logic [31:0] shamt;
    } bundle_t;
    localparam int EXP_W = $bits(bundle_t);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc_plus4 = '0;
    logic [31:0] in_inst = '0;
    logic        flush = 1'b0;
    logic        ex_load_valid = 1'b0;
    logic [4:0]  ex_load_rt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc_plus4;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [5:0]  out_opcode, out_funct;
    logic [31:0] out_imm_signed, out_imm_unsigned, out_shamt;
    logic [15:0] stall_cnt;
    logic [1:0]  dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    logic [31:0]      vec_inst[6];
    bundle_t          vec_exp[6];
    int checks = 0;
    int errors = 0;
    int w;

    id_pipe_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_plus4(in_pc_plus4), .in_inst(in_inst),
        .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rt(ex_load_rt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc_plus4(out_pc_plus4), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_opcode(out_opcode), .out_funct(out_funct),
        .out_imm_signed(out_imm_signed), .out_imm_unsigned(out_imm_unsigned),
        .out_shamt(out_shamt), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Offers vector idx until accepted; the expected bundle is queued at acceptance.
    task automatic push(input int idx, input logic [31:0] pc, output int waits);
        bundle_t e;
        bit ok;
        ok = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_inst = vec_inst[idx];
        in_pc_plus4 = pc;
        while (!ok && waits <= 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waits++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got=in_ready_low exp=accept idx=%0d", idx);
        end else begin
            e = vec_exp[idx];
            e.pc = pc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_inst[0] = 32'h8C22FFFC;  // lw $2,-4($1)
        vec_exp[0]  = '{pc:0, rs:5'd1, rt:5'd2, rd:5'd31, opcode:6'h23, funct:6'h3C,
                        imm_s:32'hFFFFFFFC, imm_u:32'h0000FFFC, shamt:32'd31};
        vec_inst[1] = 32'h00851820;  // add $3,$4,$5
        vec_exp[1]  = '{pc:0, rs:5'd4, rt:5'd5, rd:5'd3, opcode:6'h00, funct:6'h20,
                        imm_s:32'h00001820, imm_u:32'h00001820, shamt:32'd0};
        vec_inst[2] = 32'h000A49C0;  // sll $9,$10,7
        vec_exp[2]  = '{pc:0, rs:5'd0, rt:5'd10, rd:5'd9, opcode:6'h00, funct:6'h00,
                        imm_s:32'h000049C0, imm_u:32'h000049C0, shamt:32'd7};
        vec_inst[3] = 32'h2066FFFF;  // addi $6,$3,-1
        vec_exp[3]  = '{pc:0, rs:5'd3, rt:5'd6, rd:5'd31, opcode:6'h08, funct:6'h3F,
                        imm_s:32'hFFFFFFFF, imm_u:32'h0000FFFF, shamt:32'd31};
        vec_inst[4] = 32'h34078000;  // ori $7,$0,0x8000
        vec_exp[4]  = '{pc:0, rs:5'd0, rt:5'd7, rd:5'd16, opcode:6'h0D, funct:6'h00,
                        imm_s:32'hFFFF8000, imm_u:32'h00008000, shamt:32'd0};
        vec_inst[5] = 32'hAC680004;  // sw $8,4($3)
        vec_exp[5]  = '{pc:0, rs:5'd3, rt:5'd8, rd:5'd0, opcode:6'h2B, funct:6'h04,
                        imm_s:32'h00000004, imm_u:32'h00000004, shamt:32'd0};

        // Monitor: compares every issued head (valid & ready, not flushed) to the queue front.
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready && !flush) begin
                    bundle_t act;
                    logic [EXP_W-1:0] exp_v;
                    act = '{pc:out_pc_plus4, rs:out_rs, rt:out_rt, rd:out_rd,
                            opcode:out_opcode, funct:out_funct, imm_s:out_imm_signed,
                            imm_u:out_imm_unsigned, shamt:out_shamt};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL issue_unexpected got=%h exp=none", act);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (act !== exp_v) begin
                            errors++;
                            $display("FAIL issue got=%h exp=%h", act, exp_v);
                        end
                    end
                end
            end
        join_none

        // Reset state
        cycles(2);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_imm_signed", out_imm_signed, 0);
        chk("rst_pc_plus4", out_pc_plus4, 0);

        // 1: single lw, one-cycle latency
        out_ready = 1'b1;
        push(0, 32'h00000004, w);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_opcode", out_opcode, 6'h23);
        cycles(3);

        // 2: fill to TWO, third held upstream, then drain in order
        out_ready = 1'b0;
        push(0, 32'h00000010, w);
        push(1, 32'h00000014, w);
        chk("full_in_ready", in_ready, 0);
        chk("full_state", dbg_state, 2);
        fork
            push(2, 32'h00000018, w);
            begin cycles(3); out_ready = 1'b1; end
        join
        chk("held_waits", w, 4);
        cycles(4);
        chk("order_drained", exp_q.size(), 0);

        // 3: load-use bubble on rs, then ex_load_rt=0 gives no bubble
        out_ready = 1'b0;
        push(3, 32'h00000020, w);
        ex_load_valid = 1'b1;
        ex_load_rt = 5'd3;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("hazard_out_valid", out_valid, 0);
            @(posedge clk);
            #1;
        end
        ex_load_valid = 1'b0;
        chk("hazard_stall_cnt", stall_cnt, 2);
        cycles(3);
        out_ready = 1'b0;
        push(3, 32'h00000024, w);
        ex_load_valid = 1'b1;
        ex_load_rt = 5'd0;
        @(negedge clk);
        chk("rt0_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        chk("rt0_stall_cnt", stall_cnt, 2);
        ex_load_valid = 1'b0;
        out_ready = 1'b1;
        cycles(3);

        // 4: flush at TWO with an instruction offered
        out_ready = 1'b0;
        push(4, 32'h00000030, w);
        push(5, 32'h00000034, w);
        flush = 1'b1;
        in_valid = 1'b1;
        in_inst = vec_inst[0];
        @(negedge clk);
        chk("flush_cycle_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_state", dbg_state, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_stall_cnt", stall_cnt, 2);
        // flush at ONE while in_ready=1: offered instruction must still be dropped
        push(4, 32'h00000038, w);
        flush = 1'b1;
        in_valid = 1'b1;
        in_inst = vec_inst[5];
        cycles(1);
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush1_out_valid", out_valid, 0);
        chk("flush1_state", dbg_state, 0);
        out_ready = 1'b1;
        cycles(3);

        // 5: back-to-back stream of 10
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(i % 6, 32'h00000100 + 32'(4 * i), w);
            chk("stream_no_wait", w, 0);
        end
        cycles(3);
        chk("stream_drained", exp_q.size(), 0);

        // 6: saturation via rt hazard (2 already counted)
        out_ready = 1'b0;
        push(3, 32'h00000200, w);
        ex_load_valid = 1'b1;
        ex_load_rt = 5'd6;
        cycles(65533);
        chk("sat_reach", stall_cnt, 16'hFFFF);
        cycles(5);
        chk("sat_hold", stall_cnt, 16'hFFFF);
        ex_load_valid = 1'b0;
        out_ready = 1'b1;
        cycles(3);

        // Reset mid-operation drops held entries
        out_ready = 1'b0;
        push(4, 32'h00000300, w);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        exp_q.delete();
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_stall_cnt", stall_cnt, 0);
        chk("mrst_imm_unsigned", out_imm_unsigned, 0);
        out_ready = 1'b1;
        cycles(3);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
